// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (8N1 by default).
// The raw pin passes through a two-flop synchroniser. A falling edge on the
// synchronised line starts a frame. The start bit is confirmed at mid-bit,
// and each data and stop bit is then sampled one full bit period later.
// Optional feature macro: UART_RX_FRAME_ERR_EN.
//   Defined:   a frame with a low stop sample is dropped and pulses
//              uart_rx_ferr instead of uart_rx_valid.
//   Undefined: stop-bit values are ignored and uart_rx_ferr is tied low.
module uart_rx #(
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic [31:0]             cycles_per_bit,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_busy,
    output logic                    uart_rx_ferr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic                    rxd_m;
    logic                    rxd_s;
    logic                    rxd_d;
    logic [1:0]              state;
    logic [31:0]             cnt;
    logic [3:0]              bit_cnt;
    logic [PAYLOAD_BITS-1:0] sreg;

    logic [31:0] half;
    logic        start_edge;
    logic        half_tick;
    logic        bit_tick;
    logic        enter_stop;
    logic        stop_sample;
    logic        frame_done;

    assign half        = cycles_per_bit >> 1;
    // Edge rather than level, so a line held low (break) cannot retrigger.
    assign start_edge  = !rxd_s && rxd_d;
    assign half_tick   = (cnt == half);
    assign bit_tick    = (cnt == cycles_per_bit);
    assign enter_stop  = (state == ST_DATA) && bit_tick && (bit_cnt == LAST_DATA);
    assign stop_sample = (state == ST_STOP) && bit_tick;
    assign frame_done  = stop_sample && (bit_cnt == LAST_STOP);

    assign uart_rx_busy = (state != ST_IDLE);

    // Two-flop synchroniser plus one delay flop for start-edge detection.
    // All three reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    // Frame FSM with its cycle counter, bit counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            cnt     <= 32'd0;
            bit_cnt <= 4'd0;
            sreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge && uart_rx_en) begin
                        state <= ST_START;
                        cnt   <= 32'd0;
                    end
                end
                ST_START: begin
                    if (half_tick) begin
                        cnt     <= 32'd0;
                        bit_cnt <= 4'd0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state   <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        sreg <= {rxd_s, sreg[PAYLOAD_BITS-1:1]};
                        cnt  <= 32'd0;
                        if (enter_stop) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    if (stop_sample) begin
                        cnt <= 32'd0;
                        if (frame_done) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
            endcase
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    logic bad_stop;

    // Sticky flag: any low stop sample in the current frame marks it bad.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bad_stop <= 1'b0;
        end else if (enter_stop) begin
            bad_stop <= 1'b0;
        end else if (stop_sample && !rxd_s) begin
            bad_stop <= 1'b1;
        end
    end

    // Frame completion: publish a good byte, or flag a framing error and keep the old byte.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_ferr  <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_ferr  <= 1'b0;
            if (frame_done) begin
                // The final stop sample is folded in directly; bad_stop covers the earlier ones.
                if (bad_stop || !rxd_s) begin
                    uart_rx_ferr <= 1'b1;
                end else begin
                    uart_rx_data  <= sreg;
                    uart_rx_valid <= 1'b1;
                end
            end
        end
    end
`else
    // Frame completion: every finished frame is published, whatever its stop bits were.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            if (frame_done) begin
                uart_rx_data  <= sreg;
                uart_rx_valid <= 1'b1;
            end
        end
    end

    assign uart_rx_ferr = 1'b0;
`endif

endmodule
